// File: rtl/fft_frame_loader_if.sv
// fft_frame_loader_if
//   Bundles the sample stream and presented-frame signals of the FFT frame loader.
//   The master side produces samples and observes the frame. The slave side is the loader.
//   Signals:
//     s_valid      sample valid                        (master -> slave)
//     s_ready      loader can accept a sample          (slave -> master)
//     s_data       complex sample {re, im}             (master -> slave)
//     s_last       final sample of a frame             (master -> slave)
//     frame_out    presented frame, word k at [k*WORD_W +: WORD_W]
//     frame_valid  frame_out valid during the hold window
//     stage_sync   one-cycle pulse before frame_valid rises
//     err_frame    one-cycle pulse on a framing error
interface fft_frame_loader_if #(
    parameter int WORD_W = 64,
    parameter int NPTS   = 32
) ();
    logic                   s_valid;
    logic                   s_ready;
    logic [WORD_W-1:0]      s_data;
    logic                   s_last;
    logic [NPTS*WORD_W-1:0] frame_out;
    logic                   frame_valid;
    logic                   stage_sync;
    logic                   err_frame;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, frame_out, frame_valid, stage_sync, err_frame
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, frame_out, frame_valid, stage_sync, err_frame
    );
endinterface

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Input stage for the 32-point radix-2 butterfly stage 0. Collects complex samples
//   from a valid/ready stream into a frame in a fill bank, then copies the completed frame
//   into a present bank that is held stable on frame_out while the butterfly stage sweeps it.
//   A one-cycle stage_sync pulse precedes each frame_valid window to restart the stage.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    fft_frame_loader_if slave modport (stream in, frame out, sync and error pulses)
module fft_frame_loader #(
    parameter int WORD_W      = 64,
    parameter int NPTS        = 32,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    fft_frame_loader_if.slave bus
);
    localparam int IDX_W = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [WORD_W-1:0]      fill_bank_q [NPTS];
    logic [NPTS*WORD_W-1:0] frame_q, frame_d, copy_frame;
    logic [IDX_W-1:0]       widx_q, widx_d;
    logic                   fill_full_q, fill_full_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   xfer, last_slot, complete, copy_en;

    // The copy fires either from a frame already waiting in the fill bank, or straight
    // from the completing transfer when the present side is idle, so an uncontended
    // frame appears on frame_out the cycle after its last sample.
    always_comb begin
        xfer      = bus.s_valid && !fill_full_q;
        last_slot = (widx_q == IDX_W'(NPTS - 1));
        complete  = xfer && last_slot;
        copy_en   = (state_q == ST_IDLE) && (fill_full_q || complete);
    end

    // Fill-side bookkeeping. A premature s_last drops the partial frame; a full frame
    // without s_last is still kept but flagged.
    always_comb begin
        widx_d      = widx_q;
        err_d       = 1'b0;
        fill_full_d = fill_full_q;
        if (xfer) begin
            if (last_slot || bus.s_last) begin
                widx_d = '0;
            end else begin
                widx_d = widx_q + IDX_W'(1);
            end
            err_d = last_slot ? !bus.s_last : bus.s_last;
        end
        if (complete) begin
            fill_full_d = 1'b1;
        end
        if (copy_en) begin
            fill_full_d = 1'b0;
        end
    end

    // On a bypass copy the last word is still on s_data rather than in the fill bank.
    always_comb begin
        for (int k = 0; k < NPTS; k++) begin
            copy_frame[k*WORD_W +: WORD_W] = fill_bank_q[k];
        end
        if (complete) begin
            copy_frame[(NPTS-1)*WORD_W +: WORD_W] = bus.s_data;
        end
        frame_d = copy_en ? copy_frame : frame_q;
    end

    // Present-side sequencer: IDLE -> SYNC -> HOLD (cnt 1..HOLD_CYCLES) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (copy_en) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                state_d = ST_HOLD;
                cnt_d   = CNT_W'(1);
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Fill bank storage needs no reset: widx restarts at 0, so every word is rewritten
    // before a frame built from it can be copied.
    always_ff @(posedge clk) begin
        if (xfer) begin
            fill_bank_q[widx_q] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            widx_q      <= '0;
            fill_full_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            frame_q     <= '0;
        end else begin
            widx_q      <= widx_d;
            fill_full_q <= fill_full_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
        end
    end

    assign bus.s_ready     = !fill_full_q;
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = (state_q == ST_HOLD);
    assign bus.stage_sync  = (state_q == ST_SYNC);
    assign bus.err_frame   = err_q;
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
//   Scoreboard bench for fft_frame_loader. Instance A uses HOLD_CYCLES=4, instance B
//   uses HOLD_CYCLES=40 for the back-to-back backpressure scenario. A stimulus model
//   predicts completed frames and error pulses; a monitor compares them against the DUTs.
module tb_fft_frame_loader;
    localparam int W  = 64;
    localparam int N  = 32;
    localparam int FW = W * N;

    typedef struct {
        int            d;
        logic [FW-1:0] data;
        int            syncCyc;
    } frame_exp_t;

    typedef struct {
        int d;
        int cyc;
    } err_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic          sValid [2];
    logic [W-1:0]  sData [2];
    logic          sLast [2];
    logic          sReady [2];
    logic [FW-1:0] frameOut [2];
    logic          frameValid [2];
    logic          stageSync [2];
    logic          errFrame [2];

    fft_frame_loader_if #(.WORD_W(W), .NPTS(N)) ifA ();
    fft_frame_loader_if #(.WORD_W(W), .NPTS(N)) ifB ();

    fft_frame_loader #(.WORD_W(W), .NPTS(N), .HOLD_CYCLES(4))  dutA (.clk(clk), .reset(reset), .bus(ifA));
    fft_frame_loader #(.WORD_W(W), .NPTS(N), .HOLD_CYCLES(40)) dutB (.clk(clk), .reset(reset), .bus(ifB));

    assign ifA.s_valid = sValid[0];
    assign ifA.s_data  = sData[0];
    assign ifA.s_last  = sLast[0];
    assign ifB.s_valid = sValid[1];
    assign ifB.s_data  = sData[1];
    assign ifB.s_last  = sLast[1];

    assign sReady[0]     = ifA.s_ready;
    assign frameOut[0]   = ifA.frame_out;
    assign frameValid[0] = ifA.frame_valid;
    assign stageSync[0]  = ifA.stage_sync;
    assign errFrame[0]   = ifA.err_frame;
    assign sReady[1]     = ifB.s_ready;
    assign frameOut[1]   = ifB.frame_out;
    assign frameValid[1] = ifB.frame_valid;
    assign stageSync[1]  = ifB.stage_sync;
    assign errFrame[1]   = ifB.err_frame;

    // Scoreboard queues are appended by stimulus only; the monitor walks read indices.
    frame_exp_t frameQ[$];
    err_exp_t   errQ[$];
    int         fRd = 0;
    int         eRd = 0;

    logic [FW-1:0] modelFill [2];
    int            modelWidx [2];
    bit            chkLat;
    int            lastXfer;

    bit            watching [2];
    int            vcnt [2];
    logic [FW-1:0] held [2];
    int            holdExp [2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Reference model of the fill side: records a transfer made at cycle c.
    task automatic modelAccept(input int d, input logic [W-1:0] data, input logic last, input int c);
        modelFill[d][modelWidx[d]*W +: W] = data;
        if (modelWidx[d] == N - 1) begin
            frameQ.push_back('{d, modelFill[d], chkLat ? c + 1 : -1});
            if (!last) errQ.push_back('{d, c + 1});
            modelWidx[d] = 0;
        end else if (last) begin
            errQ.push_back('{d, c + 1});
            modelWidx[d] = 0;
        end else begin
            modelWidx[d]++;
        end
    endtask

    // Offers one sample and returns just after the edge that transfers it.
    task automatic applyStimulus(input int d, input logic [W-1:0] data, input logic last, input bit gaps);
        int n;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                sValid[d] = 1'b0;
            end
        end
        @(negedge clk);
        sValid[d] = 1'b1;
        sData[d]  = data;
        sLast[d]  = last;
        n = 0;
        while (!sReady[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!sReady[d]) begin
            timeoutFail("ready_wait");
            sValid[d] = 1'b0;
            return;
        end
        lastXfer = cyc;
        modelAccept(d, data, last, cyc);
        @(posedge clk);
    endtask

    task automatic sendFrame(input int d, input logic [W-1:0] base, input int n, input int lastAt, input bit gaps);
        for (int k = 0; k < n; k++) begin
            applyStimulus(d, base + W'(k), (k == lastAt), gaps);
        end
    endtask

    task automatic waitIdle(input int d);
        int n;
        @(negedge clk);
        sValid[d] = 1'b0;
        n = 0;
        while (!(fRd == frameQ.size() && eRd == errQ.size() && !watching[d]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeoutFail("wait_idle");
    endtask

    task automatic resetPulse();
        @(negedge clk);
        reset     = 1'b1;
        sValid[0] = 1'b0;
        sValid[1] = 1'b0;
        modelWidx[0] = 0;
        modelWidx[1] = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge, so values reflect the new cycle.
    always @(posedge clk) begin
        frame_exp_t fe;
        err_exp_t   ee;
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                checkOutput("rst_s_ready", 64'(sReady[d]), 64'd1);
                checkOutput("rst_frame_valid", 64'(frameValid[d]), 64'd0);
                checkOutput("rst_stage_sync", 64'(stageSync[d]), 64'd0);
                checkOutput("rst_err_frame", 64'(errFrame[d]), 64'd0);
                checks++;
                if (frameOut[d] !== '0) begin
                    failures++;
                    $display("[TB] FAIL rst_frame_out actual=nonzero required=zero dut=%0d", d);
                end
                watching[d] = 1'b0;
                vcnt[d]     = 0;
            end else begin
                if (errFrame[d]) begin
                    if (eRd >= errQ.size()) begin
                        timeoutFail("unexpected_err_frame");
                    end else begin
                        ee = errQ[eRd];
                        eRd++;
                        checkOutput("err_dut", 64'(d), 64'(ee.d));
                        checkOutput("err_cycle", 64'(cyc), 64'(ee.cyc));
                    end
                end
                if (stageSync[d]) begin
                    checkOutput("sync_while_busy", 64'(watching[d]), 64'd0);
                    checkOutput("valid_during_sync", 64'(frameValid[d]), 64'd0);
                    if (fRd >= frameQ.size()) begin
                        timeoutFail("unexpected_stage_sync");
                    end else begin
                        fe = frameQ[fRd];
                        fRd++;
                        checkOutput("frame_dut", 64'(d), 64'(fe.d));
                        for (int k = 0; k < N; k++) begin
                            checkOutput($sformatf("frame_word%0d", k), frameOut[d][k*W +: W], fe.data[k*W +: W]);
                        end
                        if (fe.syncCyc >= 0) checkOutput("sync_cycle", 64'(cyc), 64'(fe.syncCyc));
                    end
                    watching[d] = 1'b1;
                    vcnt[d]     = 0;
                    held[d]     = frameOut[d];
                end else if (frameValid[d]) begin
                    checkOutput("valid_without_sync", 64'(watching[d]), 64'd1);
                    vcnt[d]++;
                    checks++;
                    if (frameOut[d] !== held[d]) begin
                        failures++;
                        $display("[TB] FAIL frame_stable actual=changed required=held dut=%0d cycle=%0d", d, cyc);
                    end
                end else if (watching[d]) begin
                    checkOutput("hold_length", 64'(vcnt[d]), 64'(holdExp[d]));
                    watching[d] = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        int t1;
        holdExp[0] = 4;
        holdExp[1] = 40;
        for (int d = 0; d < 2; d++) begin
            sValid[d]    = 1'b0;
            sData[d]     = '0;
            sLast[d]     = 1'b0;
            modelFill[d] = '0;
            modelWidx[d] = 0;
            watching[d]  = 1'b0;
            vcnt[d]      = 0;
            held[d]      = '0;
        end
        chkLat = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] scenario 1: single frame, valid held high");
        sendFrame(0, 64'h0000_0001_0000_0000, 32, 31, 1'b0);
        waitIdle(0);

        $display("[TB] scenario 2: back-to-back frames, long hold");
        chkLat = 1'b1;
        sendFrame(1, 64'h0000_0002_0000_0000, 32, 31, 1'b0);
        t1 = lastXfer;
        chkLat = 1'b0;
        sendFrame(1, 64'h0000_0003_0000_0000, 32, 31, 1'b0);
        @(negedge clk);
        sValid[1] = 1'b0;
        checkOutput("bp_ready_low", 64'(sReady[1]), 64'd0);
        n = 0;
        while (!sReady[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_ready_return_cycle", 64'(cyc), 64'(t1 + 43));
        chkLat = 1'b1;
        waitIdle(1);

        $display("[TB] scenario 3: early s_last discards partial frame");
        sendFrame(0, 64'h0000_0004_0000_0000, 10, 9, 1'b0);
        sendFrame(0, 64'h0000_0005_0000_0000, 32, 31, 1'b0);
        waitIdle(0);

        $display("[TB] scenario 4: missing s_last on word 31");
        sendFrame(0, 64'hCAFE_0006_8000_0000, 32, -1, 1'b0);
        waitIdle(0);

        $display("[TB] scenario 5: random valid gaps");
        sendFrame(0, 64'h0000_0001_0000_0000, 32, 31, 1'b1);
        waitIdle(0);

        $display("[TB] scenario 6: reset mid-fill and mid-hold");
        sendFrame(0, 64'h0000_0007_0000_0000, 17, -1, 1'b0);
        resetPulse();
        sendFrame(0, 64'h0000_0008_0000_0000, 32, 31, 1'b0);
        @(negedge clk);
        sValid[0] = 1'b0;
        n = 0;
        while (!frameValid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!frameValid[0]) timeoutFail("hold_wait");
        resetPulse();
        sendFrame(0, 64'h7FC0_0000_FF80_0009, 32, 31, 1'b0);
        waitIdle(0);

        checkOutput("frames_pending", 64'(frameQ.size() - fRd), 64'd0);
        checkOutput("errors_pending", 64'(errQ.size() - eRd), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
